shift_sweep_accumulator: RTL
============================

Name: shift_sweep_accumulator

Overview:
- Sequencing stage wrapped around the combinational bit_shift_module.
- Upstream side: on a start request it captures a 5-bit pattern and drives num_of_ones/shift_by_n_pos through every shift position.
- Downstream side: consumes shifted_data at each position and accumulates a 10-bit sum, returned over a valid/ready handshake.
- Feeds the adder datapath of the lookahead project on EBAZ4205.

Parameters:
- PAT_W, 5, width of pattern / num_of_ones.
- DATA_W, 8, width of shifted_data.
- STEPS, 4, number of shift positions swept (0..STEPS-1); POS_W = clog2(STEPS) = 2.
- SETTLE, 1, cycles the shifter inputs are held before sampling (0 allowed).
- SUM_W, 10, accumulator width; must be ≥ DATA_W + POS_W so it never overflows.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- start  in  1  request pulse; accepted only in IDLE.
- pattern_in  in  PAT_W  pattern captured on an accepted start.
- busy  out  1  high in every state except IDLE.
- num_of_ones  out  PAT_W  registered pattern driven to the shifter.
- shift_by_n_pos  out  POS_W  registered current shift position.
- shifted_data  in  DATA_W  combinational result from the shifter.
- sum_out  out  SUM_W  accumulated sum, valid while sum_valid=1.
- sum_valid  out  1  result available.
- sum_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst_n=0 at an edge) forces state IDLE and zeroes every output and the internal accumulator and counters. Reset mid-sweep aborts the sweep with no partial result.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 → capture pattern_in into num_of_ones, clear acc, set pos=0.
  - Next state is DRIVE if SETTLE>0, otherwise SAMPLE.
  - shift_by_n_pos holds 0 while in IDLE.
- DRIVE:
  - Settle counter counts SETTLE cycles; inputs to the shifter stay stable.
  - Then → SAMPLE.
- SAMPLE (one cycle):
  - At the edge, acc ← acc + zero-extended shifted_data.
  - If pos==STEPS-1 → DONE.
  - Otherwise pos ← pos+1, then DRIVE (or SAMPLE again if SETTLE=0).
- DONE:
  - sum_valid=1, sum_out=acc.
  - sum_out, num_of_ones and shift_by_n_pos are held stable while sum_ready=0 (back-pressure, unbounded).
  - sum_valid=1 and sum_ready=1 at an edge → IDLE; sum_valid=0 and sum_out=0 next cycle; num_of_ones keeps its last value.
- Latency: sum_valid rises exactly STEPS*(SETTLE+1) edges after the edge that accepted start (8 with defaults).
- Throughput: one sweep per STEPS*(SETTLE+1)+2 cycles when sum_ready is tied high.
- start while busy=1 (including DONE) is ignored, not queued; pattern_in is ignored outside the accepting edge.
- start and sum_ready in the same DONE cycle: the handshake completes → IDLE; that start is dropped.
- Arithmetic: unsigned; maximum sum STEPS*(2^DATA_W-1)=1020 fits in SUM_W with no wrap.

Optional Feature:
- Macro SWEEP_MAX_TRACK_EN.
- When defined, adds outputs max_data [DATA_W-1:0] and max_pos [POS_W-1:0], both reset to 0.
  - In SAMPLE they update when pos==0 or shifted_data > max_data (strict, so ties keep the lowest position).
  - Valid and held alongside sum_valid; cleared on an accepted start.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Basic sweep: bench shifter model returns 8'h1B/36/6C/D8 for pos 0..3; start with pattern_in=5'b11011 → num_of_ones=5'b11011, positions 0,1,2,3 each held 2 cycles; sum_valid after 8 edges with sum_out=10'h195; with macro, max_data=8'hD8 and max_pos=3.
- Saturating data: shifted_data=8'hFF at every position → sum_out=10'h3FC with no wrap; with macro, max_pos=0 (tie rule).
- Back-pressure: sum_ready=0 for 20 cycles after sum_valid → sum_out stays 10'h195 and busy=1; release → IDLE next cycle, sum_valid=0.
- Start while busy: start pulses at sweep cycles 3 and in DONE with a different pattern → ignored, result 10'h195 unchanged; new start after IDLE is accepted.
- Reset mid-sweep: rst_n=0 at pos=2 → next cycle all outputs 0 and IDLE; a subsequent start sweeps cleanly from pos=0.
- SETTLE=0 build: same stimulus as the basic sweep → one position per cycle, sum_valid after 4 edges, sum_out=10'h195.

Source files
------------

// File: rtl/shift_sweep_accumulator.sv
// Sweeps a captured pattern through every shifter position and sums the shifted results (macro SWEEP_MAX_TRACK_EN adds max tracking).
// Result valid STEPS*(SETTLE+1) edges after start; held indefinitely under sum_ready back-pressure, new starts dropped while busy.
module shift_sweep_accumulator #(
  parameter int PAT_W  = 5,
  parameter int DATA_W = 8,
  parameter int STEPS  = 4,
  parameter int SETTLE = 1,
  parameter int SUM_W  = 10,
  localparam int POS_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern_in,
  output logic              busy,
  output logic [PAT_W-1:0]  num_of_ones,
  output logic [POS_W-1:0]  shift_by_n_pos,
  input  logic [DATA_W-1:0] shifted_data,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready
`ifdef SWEEP_MAX_TRACK_EN
  ,
  output logic [DATA_W-1:0] max_data,
  output logic [POS_W-1:0]  max_pos
`endif
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // With no settle time the shifter is sampled in the very cycle its inputs change.
  localparam state_t NEXT_POS_STATE = (SETTLE > 0) ? DRIVE : SAMPLE;

  state_t            state;
  logic [SUM_W-1:0]  acc;
  logic [CNT_W-1:0]  settle_cnt;
  logic [SUM_W-1:0]  acc_next;

  assign acc_next = acc + SUM_W'(shifted_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      num_of_ones    <= '0;
      shift_by_n_pos <= '0;
      sum_out        <= '0;
      sum_valid      <= 1'b0;
`ifdef SWEEP_MAX_TRACK_EN
      max_data       <= '0;
      max_pos        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_of_ones    <= pattern_in;
            acc            <= '0;
            shift_by_n_pos <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b1;
            state          <= NEXT_POS_STATE;
`ifdef SWEEP_MAX_TRACK_EN
            max_data       <= '0;
            max_pos        <= '0;
`endif
          end
        end
        DRIVE: begin
          if (settle_cnt == LAST_CNT) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          acc <= acc_next;
`ifdef SWEEP_MAX_TRACK_EN
          // Strict compare so ties keep the lowest position.
          if (shift_by_n_pos == '0 || shifted_data > max_data) begin
            max_data <= shifted_data;
            max_pos  <= shift_by_n_pos;
          end
`endif
          if (shift_by_n_pos == LAST_POS) begin
            sum_out   <= acc_next;
            sum_valid <= 1'b1;
            state     <= DONE;
          end else begin
            shift_by_n_pos <= shift_by_n_pos + POS_W'(1);
            state          <= NEXT_POS_STATE;
          end
        end
        DONE: begin
          if (sum_ready) begin
            sum_valid      <= 1'b0;
            sum_out        <= '0;
            busy           <= 1'b0;
            shift_by_n_pos <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
